// File: rtl/sys_mem.sv
// sys_mem: memory responder for the core's instruction and data ports.
// One unified word-addressed RAM. The instruction port is read-only and the
// data port is read/write. A byte-serial loader fills the RAM after reset and
// holds the core in reset until the image is complete.
//
// Ports:
//   clk, rst            system clock, asynchronous active-low reset
//   inst_addr_i/ce_i    fetch byte address / enable      -> inst_o
//   data_addr_i/ce_i/we_i/data_i  MEM-stage access       -> data_o
//   load_valid_i/data_i/last_i    loader byte stream (little-endian)
//   load_start_i        restart loading at word 0 (only honoured when done)
//   load_ready_o        loader may transfer a byte
//   load_done_o         image loaded
//   load_err_o          sticky: image exceeded DEPTH
//   core_rst_o          active-high reset to the core
//
// state | meaning
// ------+----------------------------------------------------------
// LOAD  | accepting loader bytes, core held in reset
// DONE  | image complete, core running, data port may write

module sys_mem #(
   parameter int DEPTH   = 1024,
   parameter int AW      = 10,
   parameter bit LOAD_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst_addr_i,
   input  logic        inst_ce_i,
   output logic [31:0] inst_o,
   input  logic [31:0] data_addr_i,
   input  logic        data_ce_i,
   input  logic        data_we_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   input  logic        load_valid_i,
   input  logic [7:0]  load_data_i,
   input  logic        load_last_i,
   input  logic        load_start_i,
   output logic        load_ready_o,
   output logic        load_done_o,
   output logic        load_err_o,
   output logic        core_rst_o
);

   localparam logic [0:0]  ST_LOAD  = 1'b0;
   localparam logic [0:0]  ST_DONE  = 1'b1;
   localparam logic [AW:0] ADDR_END = (AW+1)'(DEPTH);

   logic [31:0] mem [DEPTH];

   logic [0:0]  state_q, state_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [AW:0] load_addr_q, load_addr_d;
   logic [31:0] byte_buf_q, byte_buf_d;
   logic        err_q, err_d;
   logic        ready_q, ready_d;
   logic        done_q, done_d;
   logic        core_rst_q, core_rst_d;

   logic [AW-1:0] inst_idx, data_idx;
   logic          inst_oor, data_oor;
   logic          accept, word_full, ld_we, data_wr;
   logic [31:0]   asm_word;
   logic          unused_addr_lsbs;

   assign inst_idx = inst_addr_i[AW+1:2];
   assign data_idx = data_addr_i[AW+1:2];
   assign inst_oor = |inst_addr_i[31:AW+2];
   assign data_oor = |data_addr_i[31:AW+2];
   assign unused_addr_lsbs = ^{inst_addr_i[1:0], data_addr_i[1:0]};

   // Reads are combinational; a write in the same cycle only lands at the
   // edge, so both ports see the old word until the next cycle.
   assign inst_o = (rst && inst_ce_i && !inst_oor) ? mem[inst_idx] : 32'd0;
   assign data_o = (rst && data_ce_i && !data_we_i && !data_oor) ? mem[data_idx] : 32'd0;

   // ready_q is only set while in LOAD, so it alone qualifies acceptance.
   assign accept    = load_valid_i && ready_q;
   assign word_full = accept && ((byte_cnt_q == 2'd3) || load_last_i);
   // Buffer bytes above byte_cnt are always zero, so OR-ing in the new byte
   // also yields the zero-padded word for a short final word.
   assign asm_word  = byte_buf_q | (32'(load_data_i) << {byte_cnt_q, 3'b000});
   assign ld_we     = word_full && (load_addr_q < ADDR_END);
   // core_rst_q is high during reset, which keeps the data port from writing
   // when the block powers up directly in DONE.
   assign data_wr   = data_ce_i && data_we_i && !data_oor &&
                      (state_q == ST_DONE) && !core_rst_q;

   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      load_addr_d = load_addr_q;
      byte_buf_d  = byte_buf_q;
      err_d       = err_q;
      case (state_q)
         ST_LOAD: begin
            if (accept) begin
               byte_buf_d = asm_word;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (word_full) begin
                  byte_buf_d = 32'd0;
                  byte_cnt_d = 2'd0;
                  if (ld_we) begin
                     load_addr_d = load_addr_q + 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
               if (load_last_i) begin
                  state_d     = ST_DONE;
                  load_addr_d = '0;
               end
            end
         end
         default: begin
            if (load_start_i) begin
               state_d = ST_LOAD;
               err_d   = 1'b0;
            end
         end
      endcase
      ready_d    = (state_d == ST_LOAD);
      done_d     = (state_d == ST_DONE);
      core_rst_d = (state_d != ST_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= LOAD_EN ? ST_LOAD : ST_DONE;
         byte_cnt_q  <= 2'd0;
         load_addr_q <= '0;
         byte_buf_q  <= 32'd0;
         err_q       <= 1'b0;
         ready_q     <= 1'b0;
         done_q      <= 1'b0;
         core_rst_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         load_addr_q <= load_addr_d;
         byte_buf_q  <= byte_buf_d;
         err_q       <= err_d;
         ready_q     <= ready_d;
         done_q      <= done_d;
         core_rst_q  <= core_rst_d;
      end
   end

   // Loader and data-port writes are exclusive: one needs LOAD, the other DONE.
   always_ff @(posedge clk) begin
      if (ld_we) begin
         mem[load_addr_q[AW-1:0]] <= asm_word;
      end else if (data_wr) begin
         mem[data_idx] <= data_i;
      end
   end

   assign load_ready_o = ready_q;
   assign load_done_o  = done_q;
   assign load_err_o   = err_q;
   assign core_rst_o   = core_rst_q;

endmodule

// File: tb/tb_sys_mem.sv
// Scoreboard bench for sys_mem. Three instances share stimulus; each has its
// own reset and unused instances are parked in reset. sel picks the instance
// the monitor observes.
//   u0: DEPTH=1024, LOAD_EN=1   u1: DEPTH=4, LOAD_EN=1   u2: DEPTH=1024, LOAD_EN=0

module tb_sys_mem;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  rst_n;
   logic [31:0] inst_addr, data_addr, data_wdat;
   logic        inst_ce, data_ce, data_we;
   logic        load_valid, load_last, load_start;
   logic [7:0]  load_data;

   logic [31:0] inst_w [3];
   logic [31:0] data_w [3];
   logic        ready_w [3];
   logic        done_w [3];
   logic        err_w [3];
   logic        crst_w [3];

   int sel;
   int n_vec;
   int n_err;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } chk_t;

   chk_t inst_q[$];
   chk_t data_q[$];
   chk_t stat_q[$];

   sys_mem #(.DEPTH(1024), .AW(10), .LOAD_EN(1'b1)) u0 (
      .clk(clk), .rst(rst_n[0]),
      .inst_addr_i(inst_addr), .inst_ce_i(inst_ce), .inst_o(inst_w[0]),
      .data_addr_i(data_addr), .data_ce_i(data_ce), .data_we_i(data_we),
      .data_i(data_wdat), .data_o(data_w[0]),
      .load_valid_i(load_valid), .load_data_i(load_data), .load_last_i(load_last),
      .load_start_i(load_start), .load_ready_o(ready_w[0]), .load_done_o(done_w[0]),
      .load_err_o(err_w[0]), .core_rst_o(crst_w[0]));

   sys_mem #(.DEPTH(4), .AW(2), .LOAD_EN(1'b1)) u1 (
      .clk(clk), .rst(rst_n[1]),
      .inst_addr_i(inst_addr), .inst_ce_i(inst_ce), .inst_o(inst_w[1]),
      .data_addr_i(data_addr), .data_ce_i(data_ce), .data_we_i(data_we),
      .data_i(data_wdat), .data_o(data_w[1]),
      .load_valid_i(load_valid), .load_data_i(load_data), .load_last_i(load_last),
      .load_start_i(load_start), .load_ready_o(ready_w[1]), .load_done_o(done_w[1]),
      .load_err_o(err_w[1]), .core_rst_o(crst_w[1]));

   sys_mem #(.DEPTH(1024), .AW(10), .LOAD_EN(1'b0)) u2 (
      .clk(clk), .rst(rst_n[2]),
      .inst_addr_i(inst_addr), .inst_ce_i(inst_ce), .inst_o(inst_w[2]),
      .data_addr_i(data_addr), .data_ce_i(data_ce), .data_we_i(data_we),
      .data_i(data_wdat), .data_o(data_w[2]),
      .load_valid_i(load_valid), .load_data_i(load_data), .load_last_i(load_last),
      .load_start_i(load_start), .load_ready_o(ready_w[2]), .load_done_o(done_w[2]),
      .load_err_o(err_w[2]), .core_rst_o(crst_w[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: mid-cycle, pop one expectation per queue and compare.
   always @(negedge clk) begin
      chk_t c;
      if (inst_q.size() > 0) begin
         c = inst_q.pop_front();
         check(c.name, inst_w[sel], c.exp);
      end
      if (data_q.size() > 0) begin
         c = data_q.pop_front();
         check(c.name, data_w[sel], c.exp);
      end
      if (stat_q.size() > 0) begin
         c = stat_q.pop_front();
         check(c.name, {28'd0, ready_w[sel], done_w[sel], err_w[sel], crst_w[sel]}, c.exp);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_inst(input string name, input logic [31:0] exp);
      chk_t c;
      c.name = name;
      c.exp  = exp;
      inst_q.push_back(c);
   endtask

   task automatic push_data(input string name, input logic [31:0] exp);
      chk_t c;
      c.name = name;
      c.exp  = exp;
      data_q.push_back(c);
   endtask

   // Expected {ready, done, err, core_rst}.
   task automatic exp_stat(input string name, input logic r, input logic d,
                           input logic e, input logic cr);
      chk_t c;
      c.name = name;
      c.exp  = {28'd0, r, d, e, cr};
      stat_q.push_back(c);
   endtask

   task automatic rd_inst(input string name, input logic [31:0] addr, input logic [31:0] exp);
      inst_addr = addr;
      inst_ce   = 1'b1;
      push_inst(name, exp);
      tick();
      inst_ce   = 1'b0;
   endtask

   task automatic rd_data(input string name, input logic [31:0] addr, input logic [31:0] exp);
      data_addr = addr;
      data_ce   = 1'b1;
      data_we   = 1'b0;
      push_data(name, exp);
      tick();
      data_ce   = 1'b0;
   endtask

   task automatic wr_data(input logic [31:0] addr, input logic [31:0] val);
      data_addr = addr;
      data_wdat = val;
      data_ce   = 1'b1;
      data_we   = 1'b1;
      tick();
      data_ce   = 1'b0;
      data_we   = 1'b0;
   endtask

   task automatic put_byte(input logic [7:0] b, input logic last);
      load_valid = 1'b1;
      load_data  = b;
      load_last  = last;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] img [8];
      img = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      n_vec = 0;
      n_err = 0;
      sel   = 0;
      rst_n = 3'b000;
      inst_addr = '0; data_addr = '0; data_wdat = '0;
      inst_ce = 0; data_ce = 0; data_we = 0;
      load_valid = 0; load_last = 0; load_start = 0; load_data = '0;
      tick();

      // Reset values on u0.
      exp_stat("rst_stat", 0, 0, 0, 1);
      data_ce = 1'b1;
      push_data("rst_data_zero", 32'd0);
      rd_inst("rst_inst_zero", 32'h0, 32'd0);
      data_ce = 1'b0;

      rst_n[0] = 1'b1;
      tick();
      exp_stat("load_ready", 1, 0, 0, 1);
      tick();
      for (int i = 0; i < 8; i++) put_byte(img[i], i == 7);
      exp_stat("done_after_last", 0, 1, 0, 0);
      rd_inst("inst_w1", 32'h4, 32'h00100093);
      rd_inst("inst_w0", 32'h0, 32'h00500013);

      // Data port, read-during-write on the instruction port.
      wr_data(32'h10, 32'h11111111);
      inst_addr = 32'h10;
      inst_ce   = 1'b1;
      push_inst("rdw_old", 32'h11111111);
      wr_data(32'h10, 32'hDEADBEEF);
      push_inst("rdw_new_inst", 32'hDEADBEEF);
      rd_data("rdw_new_data", 32'h10, 32'hDEADBEEF);
      inst_ce   = 1'b0;
      data_addr = 32'h10;
      push_data("ce_off_zero", 32'd0);
      tick();
      wr_data(32'h13, 32'hCAFEF00D);
      rd_data("unaligned_wr", 32'h10, 32'hCAFEF00D);
      rd_data("oor_rd_data", 32'h1000, 32'd0);
      rd_inst("oor_rd_inst", 32'h1000, 32'd0);
      wr_data(32'h1000, 32'hFFFFFFFF);
      rd_inst("oor_wr_drop", 32'h0, 32'h00500013);
      wr_data(32'h20, 32'h55AA55AA);

      // Restart and load a short final word; data writes blocked in LOAD.
      pulse_start();
      exp_stat("restart", 1, 0, 0, 1);
      wr_data(32'h20, 32'h12345678);
      put_byte(8'hAA, 1'b0);
      put_byte(8'hBB, 1'b0);
      put_byte(8'hCC, 1'b1);
      exp_stat("partial_done", 0, 1, 0, 0);
      rd_inst("partial_w0", 32'h0, 32'h00CCBBAA);
      rd_inst("keep_w1", 32'h4, 32'h00100093);
      rd_data("no_wr_in_load", 32'h20, 32'h55AA55AA);

      // Overflow on the DEPTH=4 instance.
      rst_n[0] = 1'b0;
      rst_n[1] = 1'b1;
      sel = 1;
      tick();
      exp_stat("ovf_ready", 1, 0, 0, 1);
      tick();
      for (int k = 0; k < 5; k++) begin
         for (int j = 0; j < 4; j++) begin
            put_byte(8'(k * 16 + j), (k == 4) && (j == 3));
            if (k == 3 && j == 3) exp_stat("ovf_pre", 1, 0, 0, 1);
         end
      end
      exp_stat("ovf_err", 0, 1, 1, 0);
      tick();
      exp_stat("ovf_sticky", 0, 1, 1, 0);
      rd_inst("ovf_w0", 32'h0, 32'h03020100);
      rd_inst("ovf_w1", 32'h4, 32'h13121110);
      rd_inst("ovf_w2", 32'h8, 32'h23222120);
      rd_inst("ovf_w3", 32'hC, 32'h33323130);
      rd_inst("ovf_oor", 32'h10, 32'd0);
      pulse_start();
      exp_stat("ovf_restart", 1, 0, 0, 1);
      put_byte(8'hEE, 1'b0);
      put_byte(8'hDD, 1'b0);
      put_byte(8'hCC, 1'b0);
      put_byte(8'hBB, 1'b1);
      exp_stat("reload_done", 0, 1, 0, 0);
      rd_inst("reload_w0", 32'h0, 32'hBBCCDDEE);
      rd_inst("reload_w1", 32'h4, 32'h13121110);

      // Asynchronous reset in the middle of a word.
      pulse_start();
      put_byte(8'h11, 1'b0);
      put_byte(8'h22, 1'b0);
      rst_n[1] = 1'b0;
      exp_stat("async_rst", 0, 0, 0, 1);
      rd_inst("async_inst_zero", 32'h4, 32'd0);
      rst_n[1] = 1'b1;
      tick();
      put_byte(8'h44, 1'b0);
      put_byte(8'h33, 1'b0);
      put_byte(8'h22, 1'b0);
      put_byte(8'h11, 1'b1);
      exp_stat("fresh_done", 0, 1, 0, 0);
      rd_inst("fresh_w0", 32'h0, 32'h11223344);
      rd_inst("kept_w1", 32'h4, 32'h13121110);

      // LOAD_EN=0 instance.
      rst_n[1] = 1'b0;
      sel = 2;
      exp_stat("le0_rst", 0, 0, 0, 1);
      tick();
      rst_n[2] = 1'b1;
      tick();
      exp_stat("le0_release", 0, 1, 0, 0);
      wr_data(32'h8, 32'hA5A5A5A5);
      rd_data("le0_wr", 32'h8, 32'hA5A5A5A5);
      put_byte(8'h99, 1'b1);
      exp_stat("le0_ignore_load", 0, 1, 0, 0);
      tick();

      for (int i = 0; i < 10; i++) begin
         if (inst_q.size() + data_q.size() + stat_q.size() == 0) break;
         tick();
      end
      if (inst_q.size() + data_q.size() + stat_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending, expected 0",
                  inst_q.size() + data_q.size() + stat_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sys_mem.md
Name: sys_mem

Overview:
- Memory responder on the far end of the core's instruction and data memory interfaces. The core is the initiator on both.
- Holds one unified word-addressed RAM. Serves the instruction port read-only and the data port read/write.
- Contains a byte-serial program loader FSM. The loader fills the RAM after reset and holds the core in reset until loading completes.
- Sits at system top level, between the external host/loader link and the core.

Parameters:
- DEPTH, 1024, number of 32-bit words in RAM; must be a power of two.
- AW, 10, word-address width, log2(DEPTH).
- LOAD_EN, 1, 1 = start in LOAD after reset; 0 = start in DONE, no loading, core released immediately.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset (low = reset)
- inst_addr_i  in  32  byte address from core fetch
- inst_ce_i  in  1  instruction read enable
- inst_o  out  32  instruction word to core
- data_addr_i  in  32  byte address from core MEM stage
- data_ce_i  in  1  data access enable
- data_we_i  in  1  1 = write, 0 = read (qualified by data_ce_i)
- data_i  in  32  store data from core
- data_o  out  32  load data to core
- load_valid_i  in  1  loader byte valid
- load_data_i  in  8  loader byte, little-endian within word
- load_last_i  in  1  marks final byte of image (qualified by load_valid_i)
- load_start_i  in  1  pulse in DONE: restart loading at word 0
- load_ready_o  out  1  loader may transfer a byte
- load_done_o  out  1  image loaded
- load_err_o  out  1  sticky: image exceeded DEPTH
- core_rst_o  out  1  active-high reset to core

Behaviour:
- Addressing: word index = addr[AW+1:2]. Bits [1:0] are ignored, so no misalignment fault. Any addr with bits above AW+1 nonzero is out of range: reads return 0, writes are dropped.
- Reads, both ports: combinational. inst_o = inst_ce_i ? mem[idx] : 0. data_o = (data_ce_i && !data_we_i) ? mem[idx] : 0.
- Data write: when data_ce_i && data_we_i && state==DONE, mem[idx] <= data_i at posedge clk.
- Read-during-write, same word: both ports return the old contents in that cycle. The new value is visible from the next cycle.
- Data-port writes are ignored outside DONE, because the core is held in reset there.
- RAM contents are not reset.
- Reset (rst low):
  - state = LOAD if LOAD_EN else DONE
  - byte_cnt = 0, load_addr = 0, byte buffer = 0
  - load_err_o = 0
  - core_rst_o = 1; inst_o = data_o = 0 while rst low
  - load_ready_o = 0; load_done_o = 0
- Reset asserted mid-load abandons the partial word. Words already written are kept.
- FSM states:
  - LOAD:
    - load_ready_o = 1, core_rst_o = 1.
    - Byte accepted on load_valid_i && load_ready_o. It goes to buf[byte_cnt*8 +: 8], then byte_cnt++.
    - When byte_cnt==3 on acceptance: write {load_data_i, buf[23:0]} to mem[load_addr] at that edge, load_addr++, byte_cnt=0.
    - When load_last_i is accepted with byte_cnt<3: write the assembled word with unfilled upper bytes zeroed, in the same edge.
    - Any acceptance with load_last_i goes to DONE. byte_cnt, buf and load_addr are cleared.
  - DONE:
    - load_ready_o = 0, load_done_o = 1.
    - core_rst_o = 0 from the first cycle in DONE; it is a registered output, so one cycle after the last byte edge.
    - load_start_i = 1 goes to LOAD and clears load_done_o and load_err_o. core_rst_o = 1 on the next cycle.
- Overflow: a word write with load_addr==DEPTH is dropped and load_err_o is set (sticky). load_addr saturates at DEPTH. Bytes keep being accepted until load_last_i.
- load_valid_i is ignored outside LOAD. load_start_i is ignored outside DONE.
- All FSM outputs are registered or decoded from registered state only, with no combinational path from load_* inputs.

Test Plan:
- Reset with LOAD_EN=1; stream bytes 13,00,50,00, 93,00,10,00 with last on the 8th:
  - mem[0]=0x00500013, mem[1]=0x00100093
  - load_done_o=1 and core_rst_o=0 one cycle after the last byte
  - inst_addr_i=4 with ce=1 → inst_o=0x00100093
- Partial final word: 3 bytes AA,BB,CC with last on CC → mem[0]=0x00CCBBAA, state DONE.
- Data port in DONE:
  - Write 0xDEADBEEF to addr 0x10; same-cycle read of 0x10 returns the old value; next-cycle read returns 0xDEADBEEF.
  - ce=0 → data_o=0.
  - Write to addr 0x10|0x3 also lands in word 4.
- Out-of-range (DEPTH=1024): read addr 0x1000 → 0; write to 0x1000 leaves mem[0] unchanged.
- Overflow with DEPTH=4: load 5 full words → mem[0..3] written, load_err_o=1 sticky, load_done_o=1 after last. Then load_start_i → load_err_o=0, core_rst_o=1, load_addr restarts at 0.
- Async reset mid-word after 2 bytes → outputs take reset values immediately without a clock edge. Reloading 4 bytes writes the word at mem[0] with no stale bytes. Also run LOAD_EN=0: core_rst_o=0 in the first cycle after reset release.
